// File: rtl/result_scoreboard.sv
// Result scoreboard: queues expected words, compares them in order against observed words, and counts passes and fails.
// Optional first-fail capture ports are enabled by defining RESULT_SCOREBOARD_FIRST_FAIL_EN.
module result_scoreboard #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_num_tests,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              obs_valid,
    input  logic [DATA_W-1:0] obs_data,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              orphan,
    output logic              busy,
    output logic              done
`ifdef RESULT_SCOREBOARD_FIRST_FAIL_EN
    ,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_exp,
    output logic [DATA_W-1:0] first_fail_obs
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [OW-1:0]     occ;
    logic [CNT_W-1:0]  remaining;

    logic              fifo_empty;
    logic              push;
    logic              obs_event;
    logic              pop;
    logic              orphan_event;
    logic              mismatch;
    logic              match;
    logic [DATA_W-1:0] head;

    // Occupancy is one bit wider than the pointers so full and empty never alias.
    assign fifo_empty   = (occ == '0);
    assign exp_ready    = (state == RUN) && (occ != FULL_OCC);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

    // A start pulse overrides any same-cycle push or observation.
    assign push         = exp_valid && exp_ready && !start;
    assign obs_event    = obs_valid && (state == RUN) && !start;
    assign pop          = obs_event && !fifo_empty;
    assign orphan_event = obs_event && fifo_empty;
    assign head         = mem[rd_ptr];
    assign mismatch     = pop && (head != obs_data);
    assign match        = pop && (head == obs_data);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= exp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            remaining <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            orphan    <= 1'b0;
        end else if (start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            remaining <= cfg_num_tests;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            orphan    <= 1'b0;
            state     <= (cfg_num_tests == '0) ? DONE : RUN;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase

            if (obs_event) begin
                remaining <= remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    state <= DONE;
                end
                if (match && (pass_cnt != '1)) begin
                    pass_cnt <= pass_cnt + CNT_W'(1);
                end
                if ((mismatch || orphan_event) && (fail_cnt != '1)) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
                if (orphan_event) begin
                    orphan <= 1'b1;
                end
            end
        end
    end

`ifdef RESULT_SCOREBOARD_FIRST_FAIL_EN
    logic [CNT_W-1:0] cmp_idx;
    logic             ff_seen;

    // Only the first failing comparison of a run is latched; later fails leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_idx        <= '0;
            ff_seen        <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_obs <= '0;
        end else if (start) begin
            cmp_idx        <= '0;
            ff_seen        <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_obs <= '0;
        end else if (obs_event) begin
            cmp_idx <= cmp_idx + CNT_W'(1);
            if ((mismatch || orphan_event) && !ff_seen) begin
                ff_seen        <= 1'b1;
                first_fail_idx <= cmp_idx;
                first_fail_exp <= orphan_event ? '0 : head;
                first_fail_obs <= obs_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_result_scoreboard.sv
// Randomized self-checking bench for result_scoreboard against a queue-based reference model.
// Also checks the first-fail capture ports when RESULT_SCOREBOARD_FIRST_FAIL_EN is defined.
module tb_result_scoreboard;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;
    localparam logic [63:0] MAXC = (64'd1 << CNT_W) - 64'd1;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  cfg_num_tests;
    logic              exp_valid;
    logic              exp_ready;
    logic [DATA_W-1:0] exp_data;
    logic              obs_valid;
    logic [DATA_W-1:0] obs_data;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic              orphan;
    logic              busy;
    logic              done;
`ifdef RESULT_SCOREBOARD_FIRST_FAIL_EN
    logic [CNT_W-1:0]  first_fail_idx;
    logic [DATA_W-1:0] first_fail_exp;
    logic [DATA_W-1:0] first_fail_obs;
`endif

    always #5 clk = ~clk;

    result_scoreboard #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_num_tests(cfg_num_tests),
        .exp_valid    (exp_valid),
        .exp_ready    (exp_ready),
        .exp_data     (exp_data),
        .obs_valid    (obs_valid),
        .obs_data     (obs_data),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .orphan       (orphan),
        .busy         (busy),
        .done         (done)
`ifdef RESULT_SCOREBOARD_FIRST_FAIL_EN
        ,
        .first_fail_idx(first_fail_idx),
        .first_fail_exp(first_fail_exp),
        .first_fail_obs(first_fail_obs)
`endif
    );

    // Reference model: run state, queue of pending expected words and plain counters.
    int                m_state;
    logic [DATA_W-1:0] m_q[$];
    logic [63:0]       m_pass;
    logic [63:0]       m_fail;
    logic [63:0]       m_rem;
    logic [63:0]       m_idx;
    bit                m_orph;
    bit                m_ff_seen;
    logic [63:0]       m_ff_idx;
    logic [63:0]       m_ff_exp;
    logic [63:0]       m_ff_obs;

    int n_vec    = 0;
    int n_checks = 0;
    int n_err    = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        m_q.delete();
        m_pass    = 0;
        m_fail    = 0;
        m_rem     = 0;
        m_idx     = 0;
        m_orph    = 0;
        m_ff_seen = 0;
        m_ff_idx  = 0;
        m_ff_exp  = 0;
        m_ff_obs  = 0;
    endtask

    task automatic modelReset();
        modelClear();
        m_state = S_IDLE;
    endtask

    task automatic noteFail(input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] o);
        if (m_fail < MAXC) m_fail++;
        if (!m_ff_seen) begin
            m_ff_seen = 1;
            m_ff_idx  = m_idx;
            m_ff_exp  = 64'(e);
            m_ff_obs  = 64'(o);
        end
    endtask

    task automatic modelStep(input bit s, input logic [CNT_W-1:0] cfg, input bit ev,
                             input logic [DATA_W-1:0] ed, input bit ov, input logic [DATA_W-1:0] od);
        bit                rdy;
        logic [DATA_W-1:0] e;
        if (s) begin
            modelClear();
            m_rem   = 64'(cfg);
            m_state = (cfg == 0) ? S_DONE : S_RUN;
        end else if (m_state == S_RUN) begin
            rdy = (m_q.size() < DEPTH);
            if (ov) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    if (e == od) begin
                        if (m_pass < MAXC) m_pass++;
                    end else begin
                        noteFail(e, od);
                    end
                end else begin
                    m_orph = 1;
                    noteFail('0, od);
                end
                m_idx++;
                m_rem--;
                if (m_rem == 0) m_state = S_DONE;
            end
            if (ev && rdy) m_q.push_back(ed);
        end
    endtask

    task automatic checkOutput();
        cmp("pass_cnt",  64'(pass_cnt),  m_pass);
        cmp("fail_cnt",  64'(fail_cnt),  m_fail);
        cmp("orphan",    64'(orphan),    64'(m_orph));
        cmp("busy",      64'(busy),      64'(m_state == S_RUN));
        cmp("done",      64'(done),      64'(m_state == S_DONE));
        cmp("exp_ready", 64'(exp_ready), 64'((m_state == S_RUN) && (m_q.size() < DEPTH)));
`ifdef RESULT_SCOREBOARD_FIRST_FAIL_EN
        cmp("ff_idx", 64'(first_fail_idx), m_ff_idx);
        cmp("ff_exp", 64'(first_fail_exp), m_ff_exp);
        cmp("ff_obs", 64'(first_fail_obs), m_ff_obs);
`endif
    endtask

    // Drives one cycle of inputs at the falling edge, steps the model on the rising edge, checks at the next falling edge.
    task automatic applyStimulus(input bit s, input logic [CNT_W-1:0] cfg, input bit ev,
                                 input logic [DATA_W-1:0] ed, input bit ov, input logic [DATA_W-1:0] od);
        start         = s;
        cfg_num_tests = cfg;
        exp_valid     = ev;
        exp_data      = ed;
        obs_valid     = ov;
        obs_data      = od;
        @(posedge clk);
        modelStep(s, cfg, ev, ed, ov, od);
        @(negedge clk);
        n_vec++;
        checkOutput();
        start     = 0;
        exp_valid = 0;
        obs_valid = 0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        applyStimulus(0, '0, 1, d, 0, '0);
    endtask

    task automatic observe(input logic [DATA_W-1:0] d);
        applyStimulus(0, '0, 0, '0, 1, d);
    endtask

    task automatic begin_run(input logic [CNT_W-1:0] cfg);
        applyStimulus(1, cfg, 0, '0, 0, '0);
    endtask

    task automatic doReset();
        rst_n     = 0;
        start     = 0;
        exp_valid = 0;
        obs_valid = 0;
        modelReset();
        #1;
        checkOutput();
        @(negedge clk);
        n_vec++;
        checkOutput();
        rst_n = 1;
    endtask

    initial begin
        bit                s;
        bit                ev;
        bit                ov;
        logic [DATA_W-1:0] ed;
        logic [DATA_W-1:0] od;
        logic [CNT_W-1:0]  cfg;

        rst_n = 0; start = 0; cfg_num_tests = '0;
        exp_valid = 0; exp_data = '0; obs_valid = 0; obs_data = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput();
        cmp("rst_pass", 64'(pass_cnt), 64'd0);
        cmp("rst_ready", 64'(exp_ready), 64'd0);
        rst_n = 1;
        @(negedge clk);

        // Four in-order matches.
        begin_run(4);
        push(16'hA); push(16'hB); push(16'hC); push(16'hD);
        observe(16'hA); observe(16'hB); observe(16'hC); observe(16'hD);
        cmp("lit1_pass", 64'(pass_cnt), 64'd4);
        cmp("lit1_fail", 64'(fail_cnt), 64'd0);
        cmp("lit1_done", 64'(done), 64'd1);
        cmp("lit1_orphan", 64'(orphan), 64'd0);

        // One mismatch in the middle.
        begin_run(3);
        push(16'h10); push(16'h20); push(16'h30);
        observe(16'h10); observe(16'h21); observe(16'h30);
        cmp("lit2_pass", 64'(pass_cnt), 64'd2);
        cmp("lit2_fail", 64'(fail_cnt), 64'd1);
`ifdef RESULT_SCOREBOARD_FIRST_FAIL_EN
        cmp("lit2_ffidx", 64'(first_fail_idx), 64'd1);
        cmp("lit2_ffexp", 64'(first_fail_exp), 64'h20);
        cmp("lit2_ffobs", 64'(first_fail_obs), 64'h21);
`endif

        // Orphan observation, then a match completes the run.
        begin_run(2);
        observe(16'h5);
        cmp("lit3_fail", 64'(fail_cnt), 64'd1);
        cmp("lit3_orphan", 64'(orphan), 64'd1);
        cmp("lit3_busy", 64'(busy), 64'd1);
        push(16'h7);
        observe(16'h7);
        cmp("lit3_pass", 64'(pass_cnt), 64'd1);
        cmp("lit3_done", 64'(done), 64'd1);

        // Full FIFO: push of word 9 is refused while word 1 is popped.
        begin_run(100);
        for (int i = 1; i <= 8; i++) push(DATA_W'(i));
        cmp("lit4_full", 64'(exp_ready), 64'd0);
        applyStimulus(0, '0, 1, 16'd9, 1, 16'd1);
        cmp("lit4_ready", 64'(exp_ready), 64'd1);
        for (int i = 2; i <= 8; i++) observe(DATA_W'(i));
        cmp("lit4_pass", 64'(pass_cnt), 64'd8);
        observe(16'd9);
        cmp("lit4_orphan", 64'(orphan), 64'd1);

        // Zero-length run.
        begin_run(0);
        cmp("lit5_done", 64'(done), 64'd1);
        cmp("lit5_pass", 64'(pass_cnt), 64'd0);
        cmp("lit5_fail", 64'(fail_cnt), 64'd0);

        // Abort with a same-cycle push and observe.
        begin_run(3);
        push(16'h1);
        applyStimulus(1, 2, 1, 16'h2, 1, 16'h1);
        cmp("lit6_pass", 64'(pass_cnt), 64'd0);
        observe(16'h1);
        cmp("lit6_orphan", 64'(orphan), 64'd1);

        // Reset mid-run discards progress.
        begin_run(5);
        push(16'h3); push(16'h4);
        observe(16'h3); observe(16'h4);
        doReset();
        cmp("lit7_pass", 64'(pass_cnt), 64'd0);
        cmp("lit7_busy", 64'(busy), 64'd0);
        observe(16'h4);
        begin_run(1);
        push(16'h6);
        observe(16'h6);
        cmp("lit7_pass2", 64'(pass_cnt), 64'd1);
        cmp("lit7_done", 64'(done), 64'd1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(599) == 0) begin
                doReset();
                continue;
            end
            s   = (m_state != S_RUN) ? ($urandom_range(4) == 0) : ($urandom_range(99) < 2);
            cfg = CNT_W'($urandom_range(14));
            ev  = ($urandom_range(2) != 0);
            ed  = DATA_W'($urandom_range(7));
            ov  = ($urandom_range(2) == 0);
            if (m_q.size() > 0 && $urandom_range(3) != 0) od = m_q[0];
            else od = DATA_W'($urandom_range(7));
            applyStimulus(s, cfg, ev, ed, ov, od);
        end

        $display("[TB] %0d comparisons made", n_checks);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
